// File: rtl/cpu_datapath.sv
// cpu_datapath: SM83 execution datapath. Register file, address/data bus
// routing, ALU with flag update, IDU and PC latch; one control word per clk.
// Optional build macro: CPU_DATAPATH_HALF_CARRY_EN (nibble half-carry in H;
// when undefined, arithmetic ops write H=0 and AND writes H=1).
// reg8 encoding (s_db / t_db):
//   0=MEM 1=Z 2=W 3=B 4=C 5=D 6=E 7=H 8=L 9=SPH 10=SPL 11=PCH 12=PCL 13=A
//   14=NONE (reads 8'h00, writes discarded) 15=F
// reg16 encoding (s_ab / t_rr_wb): 0=WZ 1=BC 2=DE 3=HL 4=AF 5=SP 6=PC 7=PCH_ZERO
// IDU code 3 passes the address bus through unchanged; s_rr_wb code 3 = no writeback.
module cpu_datapath #(
  parameter logic [15:0] SP_RESET = 16'hFFFE,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  s_ab,
  input  logic [3:0]  s_db,
  input  logic [3:0]  t_db,
  input  logic        use_alu,
  input  logic [2:0]  alu_op,
  input  logic [1:0]  s_acc,
  input  logic        s_arg,
  input  logic [1:0]  idu,
  input  logic [1:0]  s_rr_wb,
  input  logic [2:0]  t_rr_wb,
  input  logic        wr_pc,
  input  logic [1:0]  cc,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [7:0]  d_in,
  output logic        cond_true,
  output logic [15:0] pc,
  output logic [15:0] sp
);

  localparam logic [3:0] R_MEM = 4'd0, R_Z = 4'd1, R_W = 4'd2, R_B = 4'd3,
                         R_C = 4'd4, R_D = 4'd5, R_E = 4'd6, R_H = 4'd7,
                         R_L = 4'd8, R_SPH = 4'd9, R_SPL = 4'd10, R_PCH = 4'd11,
                         R_PCL = 4'd12, R_A = 4'd13, R_F = 4'd15;
  localparam logic [2:0] RR_WZ = 3'd0, RR_BC = 3'd1, RR_DE = 3'd2, RR_HL = 3'd3,
                         RR_AF = 3'd4, RR_SP = 3'd5, RR_PC = 3'd6, RR_PCH_ZERO = 3'd7;
  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_XOR = 3'd5, OP_CP = 3'd7;
  localparam logic [1:0] ACC_DB = 2'd0, ACC_SPL = 2'd1, ACC_SPH = 2'd2, ACC_PCL = 2'd3;
  localparam logic [1:0] IDU_INC = 2'd0, IDU_DEC = 2'd1, IDU_ADJ = 2'd2;
  localparam logic [1:0] WB_IDU = 2'd1, WB_WZ = 2'd2;

  logic [7:0]  a_q, f_q, b_q, c_q, d_q, e_q, h_q, l_q, w_q, z_q;
  logic [15:0] sp_q, pc_q;
  logic [7:0]  a_n, f_n, b_n, c_n, d_n, e_n, h_n, l_n, w_n, z_n;
  logic [15:0] sp_n, pc_n;

  logic [7:0]  rf [16];
  logic [15:0] ab;
  logic [7:0]  db_in, acc, arg, db_res;
  logic [12:0] alu_out;
  logic [7:0]  alu_res;
  logic [3:0]  alu_flags;
  logic        alu_cy;
  logic [15:0] idu_out, rr_val;
  logic        db_wr, rr_en, flag_wr;

  // ALU: returns {raw carry, Z, N, H, C, result}. Raw carry feeds the IDU adjust.
  function automatic logic [12:0] alu_fn(input logic [2:0] op, input logic [7:0] x,
                                         input logic [7:0] y, input logic c_in,
                                         input logic keep_c);
    logic [8:0] wide;
    logic [7:0] res;
    logic       ci, cy, hf, nf, arith;
    ci    = ((op == OP_ADC) || (op == OP_SBC)) ? c_in : 1'b0;
    wide  = 9'h000;
    res   = 8'h00;
    cy    = 1'b0;
    nf    = 1'b0;
    arith = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, x} + {1'b0, y} + {8'h00, ci};
        res   = wide[7:0];
        cy    = wide[8];
        arith = 1'b1;
      end
      OP_SUB, OP_SBC, OP_CP: begin
        wide  = {1'b0, x} - {1'b0, y} - {8'h00, ci};
        res   = wide[7:0];
        cy    = wide[8];
        nf    = 1'b1;
        arith = 1'b1;
      end
      OP_AND:  res = x & y;
      OP_XOR:  res = x ^ y;
      default: res = x | y;
    endcase
`ifdef CPU_DATAPATH_HALF_CARRY_EN
    // carry/borrow into bit 4 recovered from the operand and result bits
    hf = arith ? (x[4] ^ y[4] ^ wide[4]) : (op == OP_AND);
`else
    hf = (op == OP_AND) && !arith;
`endif
    return {cy, (res == 8'h00), nf, hf, (keep_c ? c_in : cy), res};
  endfunction

  // Register file read view indexed by reg8 code (MEM and NONE slots read zero)
  always_comb begin
    rf        = '{default: 8'h00};
    rf[R_Z]   = z_q;
    rf[R_W]   = w_q;
    rf[R_B]   = b_q;
    rf[R_C]   = c_q;
    rf[R_D]   = d_q;
    rf[R_E]   = e_q;
    rf[R_H]   = h_q;
    rf[R_L]   = l_q;
    rf[R_SPH] = sp_q[15:8];
    rf[R_SPL] = sp_q[7:0];
    rf[R_PCH] = pc_q[15:8];
    rf[R_PCL] = pc_q[7:0];
    rf[R_A]   = a_q;
    rf[R_F]   = f_q;
  end

  // Address bus register-pair select
  always_comb begin
    ab = pc_q;
    case (s_ab)
      RR_WZ:       ab = {w_q, z_q};
      RR_BC:       ab = {b_q, c_q};
      RR_DE:       ab = {d_q, e_q};
      RR_HL:       ab = {h_q, l_q};
      RR_AF:       ab = {a_q, f_q};
      RR_SP:       ab = sp_q;
      RR_PCH_ZERO: ab = {pc_q[15:8], 8'h00};
      default:     ab = pc_q;
    endcase
  end

  assign db_in = (s_db == R_MEM) ? mem_rdata : rf[s_db];

  // ALU accumulator select
  always_comb begin
    acc = 8'h00;
    case (s_acc)
      ACC_DB:  acc = (t_db == R_MEM) ? db_in : rf[t_db];
      ACC_SPL: acc = sp_q[7:0];
      ACC_SPH: acc = sp_q[15:8];
      default: acc = pc_q[7:0];
    endcase
  end

  assign arg       = s_arg ? 8'h01 : db_in;
  assign alu_out   = alu_fn(alu_op, acc, arg, f_q[4], s_arg);
  assign alu_res   = alu_out[7:0];
  assign alu_flags = alu_out[11:8];
  assign alu_cy    = alu_out[12];

  // IDU: 16-bit inc/dec with wrap, or relative-jump high-byte adjust
  always_comb begin
    idu_out = ab;
    case (idu)
      IDU_INC: idu_out = ab + 16'h0001;
      IDU_DEC: idu_out = ab - 16'h0001;
      IDU_ADJ: idu_out = {ab[15:8] + {7'h00, alu_cy} - {7'h00, db_in[7]}, alu_res};
      default: idu_out = ab;
    endcase
  end

  assign db_res  = use_alu ? alu_res : db_in;
  assign db_wr   = !(use_alu && (alu_op == OP_CP));
  assign flag_wr = use_alu && (s_acc != ACC_PCL);
  assign rr_en   = (s_rr_wb == WB_IDU) || (s_rr_wb == WB_WZ);
  assign rr_val  = (s_rr_wb == WB_IDU) ? idu_out : {w_q, z_q};

  // Next register state; later assignments win, giving the collision priority
  always_comb begin
    a_n = a_q; f_n = f_q; b_n = b_q; c_n = c_q; d_n = d_q; e_n = e_q;
    h_n = h_q; l_n = l_q; w_n = w_q; z_n = z_q; sp_n = sp_q; pc_n = pc_q;
    if (rr_en) begin
      case (t_rr_wb)
        RR_WZ:   {w_n, z_n} = rr_val;
        RR_BC:   {b_n, c_n} = rr_val;
        RR_DE:   {d_n, e_n} = rr_val;
        RR_HL:   {h_n, l_n} = rr_val;
        RR_AF:   begin a_n = rr_val[15:8]; f_n = {rr_val[7:4], 4'h0}; end
        RR_SP:   sp_n = rr_val;
        RR_PC:   pc_n = rr_val;
        default: ;
      endcase
    end
    if (db_wr) begin
      case (t_db)
        R_Z:     z_n = db_res;
        R_W:     w_n = db_res;
        R_B:     b_n = db_res;
        R_C:     c_n = db_res;
        R_D:     d_n = db_res;
        R_E:     e_n = db_res;
        R_H:     h_n = db_res;
        R_L:     l_n = db_res;
        R_SPH:   sp_n[15:8] = db_res;
        R_SPL:   sp_n[7:0] = db_res;
        R_PCH:   pc_n[15:8] = db_res;
        R_PCL:   pc_n[7:0] = db_res;
        R_A:     a_n = db_res;
        R_F:     f_n = {db_res[7:4], 4'h0};
        default: ;
      endcase
    end
    if (wr_pc)   pc_n = idu_out;
    if (flag_wr) f_n = {alu_flags, 4'h0};
  end

  // Register file commit; reset clears everything and blocks all writes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= 8'h00; f_q <= 8'h00; b_q <= 8'h00; c_q <= 8'h00; d_q <= 8'h00;
      e_q <= 8'h00; h_q <= 8'h00; l_q <= 8'h00; w_q <= 8'h00; z_q <= 8'h00;
      sp_q <= SP_RESET;
      pc_q <= PC_RESET;
    end else begin
      a_q <= a_n; f_q <= f_n; b_q <= b_n; c_q <= c_n; d_q <= d_n;
      e_q <= e_n; h_q <= h_n; l_q <= l_n; w_q <= w_n; z_q <= z_n;
      sp_q <= sp_n;
      pc_q <= pc_n;
    end
  end

  // Condition code evaluation against the current flags
  always_comb begin
    case (cc)
      2'd0:    cond_true = !f_q[7];
      2'd1:    cond_true = f_q[7];
      2'd2:    cond_true = !f_q[4];
      default: cond_true = f_q[4];
    endcase
  end

  assign mem_addr  = ab;
  assign mem_wdata = db_res;
  assign mem_we    = !rst && db_wr && (t_db == R_MEM);
  assign d_in      = mem_rdata;
  assign pc        = pc_q;
  assign sp        = sp_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: self-checking bench for cpu_datapath (table vectors,
// hand-written sequences, and randomized ALU/IDU traffic against a model).
module tb_cpu_datapath;

  localparam logic [3:0] R_MEM = 4'd0, R_Z = 4'd1, R_W = 4'd2, R_B = 4'd3,
                         R_C = 4'd4, R_A = 4'd13, R_NONE = 4'd14, R_F = 4'd15;
  localparam logic [2:0] RR_WZ = 3'd0, RR_BC = 3'd1, RR_HL = 3'd3, RR_AF = 3'd4,
                         RR_SP = 3'd5, RR_PC = 3'd6;
  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR = 3'd6, OP_CP = 3'd7;
  localparam logic [1:0] ACC_DB = 2'd0, ACC_PCL = 2'd3;
  localparam logic [1:0] IDU_INC = 2'd0, IDU_DEC = 2'd1, IDU_ADJ = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd0, WB_IDU = 2'd1, WB_WZ = 2'd2;
`ifdef CPU_DATAPATH_HALF_CARRY_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] s_ab;
    logic [3:0] s_db;
    logic [3:0] t_db;
    logic       use_alu;
    logic [2:0] alu_op;
    logic [1:0] s_acc;
    logic       s_arg;
    logic [1:0] idu;
    logic [1:0] s_rr_wb;
    logic [2:0] t_rr_wb;
    logic       wr_pc;
  } ctl_t;

  typedef struct {
    logic [2:0] op;
    logic       one;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] fin;
    logic [7:0] exp_a;
    logic [7:0] exp_f;
  } alu_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ctl_t        cur;
  logic [1:0]  cc = 2'd0;
  logic [15:0] mem_addr, pc, sp;
  logic [7:0]  mem_rdata, mem_wdata, d_in;
  logic        mem_we, cond_true;
  logic [7:0]  mem [0:65535];
  logic        rd_ovr_en = 1'b0;
  logic [7:0]  rd_ovr = 8'h00;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;
  int          checks = 0;
  int          failures = 0;

  cpu_datapath dut (
    .clk(clk), .rst(rst), .s_ab(cur.s_ab), .s_db(cur.s_db), .t_db(cur.t_db),
    .use_alu(cur.use_alu), .alu_op(cur.alu_op), .s_acc(cur.s_acc), .s_arg(cur.s_arg),
    .idu(cur.idu), .s_rr_wb(cur.s_rr_wb), .t_rr_wb(cur.t_rr_wb), .wr_pc(cur.wr_pc),
    .cc(cc), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .d_in(d_in), .cond_true(cond_true), .pc(pc), .sp(sp)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rd_ovr_en ? rd_ovr : mem[mem_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c = '0;
    c.s_ab = RR_PC;
    c.s_db = R_MEM;
    c.t_db = R_NONE;
    c.idu = IDU_INC;
    c.s_rr_wb = WB_NONE;
    return c;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur = idle_ctl();
  endtask

  task automatic step(input ctl_t c);
    cur = c;
    tick();
  endtask

  task automatic poke(input logic [15:0] addr, input logic [7:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic load8(input logic [3:0] r, input logic [7:0] v);
    ctl_t c;
    c = idle_ctl();
    c.s_db = R_MEM;
    c.t_db = r;
    rd_ovr_en = 1'b1;
    rd_ovr = v;
    step(c);
    rd_ovr_en = 1'b0;
  endtask

  task automatic load16(input logic [2:0] rr, input logic [15:0] v);
    ctl_t c;
    load8(R_W, v[15:8]);
    load8(R_Z, v[7:0]);
    c = idle_ctl();
    c.s_rr_wb = WB_WZ;
    c.t_rr_wb = rr;
    step(c);
  endtask

  task automatic peek(input logic [2:0] rr, output logic [15:0] v);
    cur = idle_ctl();
    cur.s_ab = rr;
    #1;
    v = mem_addr;
    cur = idle_ctl();
  endtask

  function automatic logic [7:0] hc_adj(input logic [7:0] f, input logic [2:0] op);
    if (HC) return f;
    return (op == OP_AND) ? (f | 8'h20) : (f & 8'hDF);
  endfunction

  // Reference ALU: plain integer arithmetic, returns {new A, new F}
  function automatic logic [15:0] ref_alu(input int op, input bit one, input int a,
                                          input int b, input logic [7:0] fin);
    int y, ci, r, r8;
    bit z, n, h, c;
    y = one ? 1 : b;
    ci = ((op == 1) || (op == 3)) ? int'(fin[4]) : 0;
    n = 0; h = 0; c = 0;
    case (op)
      0, 1: begin r = a + y + ci; c = (r > 255); h = ((a & 15) + (y & 15) + ci) > 15; end
      2, 3, 7: begin r = a - y - ci; c = (r < 0); h = ((a & 15) - (y & 15) - ci) < 0; n = 1; end
      4: begin r = a & y; h = 1; end
      5: r = a ^ y;
      default: r = a | y;
    endcase
    r8 = r & 255;
    z = (r8 == 0);
    if (one) c = fin[4];
    if (!HC) h = (op == 4);
    return {(op == 7) ? 8'(a) : 8'(r8), z, n, h, c, 4'h0};
  endfunction

  task automatic alu_exec(input logic [2:0] op, input logic one, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] fin);
    ctl_t c;
    load8(R_A, a);
    load8(R_B, b);
    load8(R_F, fin);
    c = idle_ctl();
    c.s_db = R_B;
    c.t_db = R_A;
    c.use_alu = 1'b1;
    c.alu_op = op;
    c.s_acc = ACC_DB;
    c.s_arg = one;
    step(c);
  endtask

  initial begin
    ctl_t c;
    logic [15:0] v, v2, pc0;
    alu_vec_t tbl [15];
    bit one;
    int op;
    logic [7:0] ra, rb, rf;

    tbl[0]  = '{OP_ADD, 1'b0, 8'h3A, 8'hC6, 8'h00, 8'h00, 8'hB0};
    tbl[1]  = '{OP_ADC, 1'b0, 8'h0F, 8'h00, 8'h10, 8'h10, 8'h20};
    tbl[2]  = '{OP_SUB, 1'b0, 8'h3E, 8'h3E, 8'h00, 8'h00, 8'hC0};
    tbl[3]  = '{OP_SUB, 1'b0, 8'h3E, 8'h0F, 8'h00, 8'h2F, 8'h60};
    tbl[4]  = '{OP_SBC, 1'b0, 8'h3B, 8'h2A, 8'h10, 8'h10, 8'h40};
    tbl[5]  = '{OP_SBC, 1'b0, 8'h00, 8'h00, 8'h10, 8'hFF, 8'h70};
    tbl[6]  = '{OP_AND, 1'b0, 8'h5A, 8'h3F, 8'h10, 8'h1A, 8'h20};
    tbl[7]  = '{OP_AND, 1'b0, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'hA0};
    tbl[8]  = '{OP_XOR, 1'b0, 8'hFF, 8'hFF, 8'h70, 8'h00, 8'h80};
    tbl[9]  = '{OP_OR,  1'b0, 8'h5A, 8'hA5, 8'hF0, 8'hFF, 8'h00};
    tbl[10] = '{OP_CP,  1'b0, 8'h3C, 8'h40, 8'h00, 8'h3C, 8'h50};
    tbl[11] = '{OP_ADD, 1'b1, 8'hFF, 8'h00, 8'h10, 8'h00, 8'hB0};
    tbl[12] = '{OP_ADD, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA0};
    tbl[13] = '{OP_SUB, 1'b1, 8'h10, 8'h00, 8'h10, 8'h0F, 8'h70};
    tbl[14] = '{OP_SUB, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'hC0};

    // Reset held two cycles with write-heavy controls applied
    c = idle_ctl();
    c.s_db = R_A; c.t_db = R_MEM; c.wr_pc = 1'b1; c.s_rr_wb = WB_WZ; c.t_rr_wb = RR_SP;
    cur = c;
    #1;
    chk("reset_mem_we_0", 16'(mem_we), 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_mem_we_1", 16'(mem_we), 16'h0000);
    rst = 1'b0;
    cur = idle_ctl();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_sp", sp, 16'hFFFE);
    peek(RR_AF, v); chk("reset_af", v, 16'h0000);
    peek(RR_BC, v); chk("reset_bc", v, 16'h0000);
    peek(RR_WZ, v); chk("reset_wz", v, 16'h0000);

    // LD B,n
    poke(16'h0000, 8'h5A);
    c = idle_ctl();
    c.s_ab = RR_PC; c.idu = IDU_INC; c.wr_pc = 1'b1; c.s_db = R_MEM; c.t_db = R_Z;
    cur = c;
    #1;
    chk("ldbn_d_in", 16'(d_in), 16'h005A);
    tick();
    chk("ldbn_pc1", pc, 16'h0001);
    peek(RR_WZ, v); chk("ldbn_z", 16'(v[7:0]), 16'h005A);
    c = idle_ctl();
    c.s_db = R_Z; c.t_db = R_B; c.wr_pc = 1'b1;
    step(c);
    chk("ldbn_pc2", pc, 16'h0002);
    peek(RR_BC, v); chk("ldbn_bc", v, 16'h5A00);

    // ADD A,B and CP A,B
    alu_exec(OP_ADD, 1'b0, 8'hFF, 8'h01, 8'h00);
    peek(RR_AF, v); chk("add_ff_01", v, {8'h00, HC ? 8'hB0 : 8'h90});
    alu_exec(OP_CP, 1'b0, 8'h3C, 8'h3C, 8'h00);
    peek(RR_AF, v); chk("cp_equal", v, 16'h3CC0);

    // JR e: forward and backward
    load8(R_F, 8'h50);
    for (int k = 0; k < 2; k++) begin
      load16(RR_PC, (k == 0) ? 16'h01FE : 16'h0110);
      load8(R_Z, (k == 0) ? 8'h05 : 8'hFE);
      c = idle_ctl();
      c.s_ab = RR_PC; c.idu = IDU_ADJ; c.s_acc = ACC_PCL; c.use_alu = 1'b1;
      c.alu_op = OP_ADD; c.s_db = R_Z; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_WZ;
      step(c);
      peek(RR_WZ, v); chk("jr_wz", v, (k == 0) ? 16'h0203 : 16'h010E);
      peek(RR_AF, v); chk("jr_f_kept", 16'(v[7:0]), 16'h0050);
      c = idle_ctl();
      c.s_ab = RR_WZ; c.idu = IDU_INC; c.wr_pc = 1'b1;
      step(c);
      chk("jr_pc", pc, (k == 0) ? 16'h0204 : 16'h010F);
    end

    // PUSH BC, then POP AF
    load16(RR_SP, 16'hFFFE);
    load16(RR_BC, 16'h1234);
    c = idle_ctl();
    c.s_ab = RR_SP; c.idu = IDU_DEC; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_SP;
    step(c);
    c.s_db = R_B; c.t_db = R_MEM;
    cur = c;
    #1;
    chk("push_we", 16'(mem_we), 16'h0001);
    chk("push_addr", mem_addr, 16'hFFFD);
    chk("push_wdata", 16'(mem_wdata), 16'h0012);
    tick();
    c = idle_ctl();
    c.s_ab = RR_SP; c.s_db = R_C; c.t_db = R_MEM;
    step(c);
    chk("push_hi", 16'(mem[16'hFFFD]), 16'h0012);
    chk("push_lo", 16'(mem[16'hFFFC]), 16'h0034);
    chk("push_sp", sp, 16'hFFFC);
    load16(RR_AF, 16'h123F);
    peek(RR_AF, v); chk("pop_af", v, 16'h1230);

    // Condition codes with F=80
    load8(R_F, 8'h80);
    for (int k = 0; k < 4; k++) begin
      cc = 2'(k);
      #1;
      chk("cond_true", 16'(cond_true), (k == 1 || k == 2) ? 16'h0001 : 16'h0000);
    end

    // INC SP wrap and DEC SP wrap
    load16(RR_SP, 16'hFFFF);
    c = idle_ctl();
    c.s_ab = RR_SP; c.idu = IDU_INC; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_SP;
    step(c);
    chk("inc_sp_wrap", sp, 16'h0000);
    c.idu = IDU_DEC;
    step(c);
    chk("dec_sp_wrap", sp, 16'hFFFF);

    // Collisions and same-cycle read of old values
    load16(RR_WZ, 16'h1234);
    pc0 = pc;
    c = idle_ctl();
    c.s_ab = RR_PC; c.idu = IDU_INC; c.wr_pc = 1'b1; c.s_rr_wb = WB_WZ; c.t_rr_wb = RR_PC;
    step(c);
    chk("wrpc_beats_rr", pc, 16'((int'(pc0) + 1) & 16'hFFFF));
    c = idle_ctl();
    c.s_db = R_MEM; c.t_db = R_B; c.s_rr_wb = WB_WZ; c.t_rr_wb = RR_BC;
    rd_ovr_en = 1'b1; rd_ovr = 8'h77;
    step(c);
    rd_ovr_en = 1'b0;
    peek(RR_BC, v); chk("tdb_beats_rr", v, 16'h7734);
    c = idle_ctl();
    c.s_db = R_B; c.t_db = R_A; c.s_rr_wb = WB_WZ; c.t_rr_wb = RR_BC;
    step(c);
    peek(RR_AF, v); chk("raw_old_b", 16'(v[15:8]), 16'h0077);
    peek(RR_BC, v); chk("raw_new_bc", v, 16'h1234);
    load8(R_F, 8'h30);
    c = idle_ctl();
    c.s_db = R_MEM; c.t_db = R_F; c.use_alu = 1'b1; c.alu_op = OP_XOR; c.s_acc = ACC_DB;
    rd_ovr_en = 1'b1; rd_ovr = 8'h30;
    step(c);
    rd_ovr_en = 1'b0;
    peek(RR_AF, v); chk("flag_beats_tdb_f", 16'(v[7:0]), 16'h0080);
    load8(R_F, 8'h5A);
    peek(RR_AF, v); chk("tdb_f_mask", 16'(v[7:0]), 16'h0050);

    // ALU vector table
    foreach (tbl[i]) begin
      alu_exec(tbl[i].op, tbl[i].one, tbl[i].a, tbl[i].b, tbl[i].fin);
      peek(RR_AF, v);
      chk($sformatf("alu_tbl_%0d", i), v, {tbl[i].exp_a, hc_adj(tbl[i].exp_f, tbl[i].op)});
    end

    // Randomized ALU against the reference model
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 7));
      one = ((op == 0) || (op == 2)) ? bit'($urandom_range(0, 1)) : 1'b0;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 8'($urandom) & 8'hF0;
      alu_exec(3'(op), one, ra, rb, rf);
      peek(RR_AF, v);
      v2 = ref_alu(op, one, int'(ra), int'(rb), rf);
      chk($sformatf("alu_rand op=%0d one=%0d a=%h b=%h f=%h", op, one, ra, rb, rf), v, v2);
    end

    // Randomized HL increment/decrement
    for (int i = 0; i < 40; i++) begin
      v2 = 16'($urandom);
      if (i == 0) v2 = 16'hFFFF;
      if (i == 1) v2 = 16'h0000;
      one = bit'(i & 1);
      load16(RR_HL, v2);
      c = idle_ctl();
      c.s_ab = RR_HL; c.idu = one ? IDU_DEC : IDU_INC; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_HL;
      step(c);
      peek(RR_HL, v);
      chk($sformatf("idu_hl %h dec=%0d", v2, one), v,
          16'((int'(v2) + (one ? -1 : 1)) & 16'hFFFF));
    end

    // Randomized relative jump target
    for (int i = 0; i < 30; i++) begin
      v2 = 16'($urandom);
      ra = 8'($urandom);
      load16(RR_PC, v2);
      load8(R_Z, ra);
      c = idle_ctl();
      c.s_ab = RR_PC; c.idu = IDU_ADJ; c.s_acc = ACC_PCL; c.use_alu = 1'b1;
      c.alu_op = OP_ADD; c.s_db = R_Z; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_WZ;
      step(c);
      peek(RR_WZ, v);
      chk($sformatf("jr_rand pc=%h e=%h", v2, ra), v,
          16'((int'(v2) + int'($signed(ra))) & 16'hFFFF));
    end

    // Reset in the middle of activity
    load16(RR_BC, 16'hBEEF);
    load16(RR_SP, 16'h4321);
    c = idle_ctl();
    c.s_db = R_B; c.t_db = R_MEM; c.wr_pc = 1'b1; c.s_rr_wb = WB_IDU; c.t_rr_wb = RR_AF;
    rst = 1'b1;
    cur = c;
    #1;
    chk("midrst_mem_we", 16'(mem_we), 16'h0000);
    tick();
    rst = 1'b0;
    chk("midrst_pc", pc, 16'h0000);
    chk("midrst_sp", sp, 16'hFFFE);
    peek(RR_BC, v); chk("midrst_bc", v, 16'h0000);
    peek(RR_AF, v); chk("midrst_af", v, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
